amplitude_loop_sequencer: RTL

//  Schedules the amplitude control loop. Measures the peak |sample| over a fixed window and

---
 rtl/amplitude_loop_sequencer.sv | 118 +++++++++++
 1 files changed

// File: rtl/amplitude_loop_sequencer.sv
// Amplitude control loop scheduler: windowed peak detect, scaled error issue, settle wait.
// Optional `DEADBAND_EN suppresses updates whose |setpoint - peak| is within DEADBAND.
module amplitude_loop_sequencer #(
  parameter int WINDOW_LEN = 1024,
  parameter int SETTLE_CYC = 256,
  parameter int GAIN_SHIFT = 4,
  parameter int DEADBAND   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable_i,
  input  logic [15:0]        setpoint_i,
  input  logic signed [15:0] sample_i,
  input  logic               sample_valid_i,
  output logic signed [31:0] eps_o,
  output logic               valid_o,
  output logic               busy_o,
  output logic [1:0]         state_o,
  output logic [15:0]        update_cnt_o
);
  localparam int WW = (WINDOW_LEN > 1) ? $clog2(WINDOW_LEN) : 1;
  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [WW-1:0] WIN_LAST    = WW'(WINDOW_LEN - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, MEASURE = 2'd2, UPDATE = 2'd3} state_t;

  state_t           state;
  logic [SW-1:0]    settle_cnt;
  logic [WW-1:0]    samp_cnt;
  logic [16:0]      peak;
  logic signed [16:0] sx;
  logic [16:0]      abs_s;
  logic signed [17:0] diff;
  logic signed [31:0] eps;
  logic             fire;

  assign state_o = state;

  // 17-bit magnitude so that |-32768| is representable
  always_comb begin
    sx    = {sample_i[15], sample_i};
    abs_s = sx[16] ? 17'(-sx) : 17'(sx);
    diff  = $signed({2'b00, setpoint_i}) - $signed({1'b0, peak});
    eps   = $signed({{14{diff[17]}}, diff}) <<< (16 - GAIN_SHIFT);
  end

`ifdef DEADBAND_EN
  logic [17:0] mag;
  always_comb begin
    mag  = diff[17] ? 18'(-diff) : 18'(diff);
    fire = (mag > 18'(DEADBAND));
  end
`else
  assign fire = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      settle_cnt   <= '0;
      samp_cnt     <= '0;
      peak         <= '0;
      eps_o        <= '0;
      valid_o      <= 1'b0;
      busy_o       <= 1'b0;
      update_cnt_o <= '0;
    end else begin
      valid_o <= 1'b0;
      if (!enable_i) begin
        // disable wins in every state, including UPDATE: pending result is dropped
        state      <= IDLE;
        busy_o     <= 1'b0;
        settle_cnt <= '0;
        samp_cnt   <= '0;
        peak       <= '0;
        eps_o      <= '0;
      end else begin
        case (state)
          IDLE: begin
            state      <= SETTLE;
            busy_o     <= 1'b1;
            settle_cnt <= '0;
          end
          SETTLE: begin
            if (settle_cnt == SETTLE_LAST) begin
              state    <= MEASURE;
              peak     <= '0;
              samp_cnt <= '0;
            end else begin
              settle_cnt <= settle_cnt + 1'b1;
            end
          end
          MEASURE: begin
            if (sample_valid_i) begin
              if (abs_s > peak) peak <= abs_s;
              if (samp_cnt == WIN_LAST) state <= UPDATE;
              else samp_cnt <= samp_cnt + 1'b1;
            end
          end
          UPDATE: begin
            if (fire) begin
              eps_o        <= eps;
              valid_o      <= 1'b1;
              update_cnt_o <= update_cnt_o + 1'b1;
            end
            state      <= SETTLE;
            settle_cnt <= '0;
          end
          default: begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule
